pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the ALU forwarding unit. It handles the hazards forwarding cannot resolve: load-use dependencies, taken branches and multi-cycle data-memory accesses. It drives the PC and per-stage pipeline-register write enables and flushes, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/load_use_detect.sv | 26 ++
 rtl/pipeline_stall_controller.sv | 122 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// State encoding doubles as the externally visible stall_state code.
package pipeline_ctrl_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int LU_CNT_W           = 3;

  typedef enum logic [1:0] {
    STATE_RUN      = 2'b00,
    STATE_LU_STALL = 2'b01,
    STATE_MEM_WAIT = 2'b10
  } stall_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source the ID instruction actually reads.
// Purely combinational; x0 is hard-wired zero so it never creates a dependency.
module load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_mem_read_i,
  output logic                  lu_hazard_o
);

  logic rd_nonzero;
  logic rs1_match;
  logic rs2_match;

  assign rd_nonzero  = (ex_rd_addr_i != '0);
  assign rs1_match   = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_match   = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
  assign lu_hazard_o = ex_mem_read_i && rd_nonzero && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, memory freezes.
// Outputs are Mealy so a hazard stalls the pipeline in the same cycle it is seen.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W      = DEFAULT_REG_ADDR_W,
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_write_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write_en,
  output logic                  mem_wb_write_en,
  output logic [1:0]            stall_state,
  output logic [CNT_W-1:0]      stall_cycle_count
);

  localparam logic [LU_CNT_W-1:0] LU_ONE    = LU_CNT_W'(1);
  localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

  stall_state_e          state_q, state_d;
  logic [LU_CNT_W-1:0]   bub_q, bub_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  lu_hazard;
  logic                  lu_pending;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_rs1_addr_i (id_rs1_addr),
    .id_rs2_addr_i (id_rs2_addr),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_used_i (id_rs2_used),
    .ex_rd_addr_i  (ex_rd_addr),
    .ex_mem_read_i (ex_mem_read),
    .lu_hazard_o   (lu_hazard)
  );

  // A freeze that interrupted a bubble sequence keeps a nonzero count, which resumes it.
  assign lu_pending = (state_q == STATE_LU_STALL) ||
                      ((state_q == STATE_MEM_WAIT) && (bub_q != '0));

  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_write_en  = 1'b1;
    id_ex_flush     = 1'b0;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    state_d         = STATE_RUN;
    bub_d           = bub_q;

    if (!reset) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_write_en  = 1'b0;
      id_ex_flush     = 1'b1;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
      bub_d           = '0;
    end else if (dmem_busy) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
      state_d         = STATE_MEM_WAIT;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      bub_d       = '0;
    end else if (lu_pending) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
      bub_d          = (bub_q != '0) ? bub_q - LU_ONE : '0;
      state_d        = (bub_q <= LU_ONE) ? STATE_RUN : STATE_LU_STALL;
    end else if (lu_hazard) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
      if (LOAD_USE_STALLS > 1) begin
        state_d = STATE_LU_STALL;
        bub_d   = LU_RELOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= STATE_RUN;
      bub_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      if (!pc_write_en && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign stall_state       = state_q;
  assign stall_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: decode table plus multi-cycle sequences
// on three instances (default, LOAD_USE_STALLS=3, CNT_W=4) sharing one input set.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, branch_taken, dmem_busy;

  logic        pc0, ifwe0, iffl0, idwe0, idfl0, exwe0, mwwe0;
  logic [1:0]  st0;
  logic [15:0] cnt0;
  logic        pc3, ifwe3, iffl3, idwe3, idfl3, exwe3, mwwe3;
  logic [1:0]  st3;
  logic [15:0] cnt3;
  logic        pcs, ifwes, iffls, idwes, idfls, exwes, mwwes;
  logic [1:0]  sts;
  logic [3:0]  cnts;

  logic [6:0] out0, out3;
  assign out0 = {pc0, ifwe0, iffl0, idwe0, idfl0, exwe0, mwwe0};
  assign out3 = {pc3, ifwe3, iffl3, idwe3, idfl3, exwe3, mwwe3};

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we}
  localparam logic [6:0] O_RUN    = 7'b1101011;
  localparam logic [6:0] O_STALL  = 7'b0001111;
  localparam logic [6:0] O_BRANCH = 7'b1111111;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_RESET  = 7'b0010100;

  pipeline_stall_controller u_dut (
    .clk(clk), .reset(reset), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write_en(pc0), .if_id_write_en(ifwe0), .if_id_flush(iffl0), .id_ex_write_en(idwe0),
    .id_ex_flush(idfl0), .ex_mem_write_en(exwe0), .mem_wb_write_en(mwwe0),
    .stall_state(st0), .stall_cycle_count(cnt0));

  pipeline_stall_controller #(.LOAD_USE_STALLS(3)) u_dut3 (
    .clk(clk), .reset(reset), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write_en(pc3), .if_id_write_en(ifwe3), .if_id_flush(iffl3), .id_ex_write_en(idwe3),
    .id_ex_flush(idfl3), .ex_mem_write_en(exwe3), .mem_wb_write_en(mwwe3),
    .stall_state(st3), .stall_cycle_count(cnt3));

  pipeline_stall_controller #(.CNT_W(4)) u_dut_sat (
    .clk(clk), .reset(reset), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write_en(pcs), .if_id_write_en(ifwes), .if_id_flush(iffls), .id_ex_write_en(idwes),
    .id_ex_flush(idfls), .ex_mem_write_en(exwes), .mem_wb_write_en(mwwes),
    .stall_state(sts), .stall_cycle_count(cnts));

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       busy;
    logic [6:0] exp_out;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic busy);
    id_rs1_addr  = r1;
    id_rs2_addr  = r2;
    id_rs1_used  = u1;
    id_rs2_used  = u2;
    ex_rd_addr   = rd;
    ex_mem_read  = mr;
    branch_taken = br;
    dmem_busy    = busy;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hazard_in();
    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_in();
    edge_step();
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN,    2'b00};
    vecs[1]  = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_STALL,  2'b00};
    vecs[2]  = '{5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, O_STALL,  2'b00};
    vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN,    2'b00};
    vecs[4]  = '{5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, O_RUN,    2'b00};
    vecs[5]  = '{5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_RUN,    2'b00};
    vecs[6]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, O_BRANCH, 2'b00};
    vecs[7]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, O_FREEZE, 2'b10};
    vecs[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, O_RUN,    2'b00};
    vecs[9]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, O_FREEZE, 2'b10};
    vecs[10] = '{5'd4, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, O_STALL,  2'b00};
    vecs[11] = '{5'd6, 5'd6, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, O_STALL,  2'b00};

    // Outputs held in the reset pattern even with a hazard on the inputs.
    reset = 1'b0;
    hazard_in();
    @(negedge clk);
    chk("reset_out", {25'd0, out0}, {25'd0, O_RESET});
    edge_step();
    chk("reset_state", {30'd0, st0}, 32'd0);
    chk("reset_count", {16'd0, cnt0}, 32'd0);
    reset = 1'b1;

    // Single load-use bubble with default depth.
    hazard_in();
    @(negedge clk);
    chk("lu_stall_out", {25'd0, out0}, {25'd0, O_STALL});
    edge_step();
    idle_in();
    @(negedge clk);
    chk("lu_after_out", {25'd0, out0}, {25'd0, O_RUN});
    chk("lu_count", {16'd0, cnt0}, 32'd1);
    edge_step();

    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
             vecs[i].mr, vecs[i].br, vecs[i].busy);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), {25'd0, out0}, {25'd0, vecs[i].exp_out});
      edge_step();
      chk($sformatf("vec%0d_state", i), {30'd0, st0}, {30'd0, vecs[i].exp_state});
    end
    chk("table_count", {16'd0, cnt0}, 32'd6);

    // Three-cycle memory wait, then release straight into run.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("memwait%0d_out", i), {25'd0, out0}, {25'd0, O_FREEZE});
      edge_step();
      chk($sformatf("memwait%0d_state", i), {30'd0, st0}, 32'd2);
    end
    idle_in();
    @(negedge clk);
    chk("memrel_out", {25'd0, out0}, {25'd0, O_RUN});
    chk("memwait_count", {16'd0, cnt0}, 32'd3);
    edge_step();
    chk("memrel_state", {30'd0, st0}, 32'd0);

    // Three-bubble load-use interrupted by a freeze on the second bubble.
    do_reset();
    hazard_in();
    @(negedge clk);
    chk("lu3_b1_out", {25'd0, out3}, {25'd0, O_STALL});
    edge_step();
    chk("lu3_b1_state", {30'd0, st3}, 32'd1);
    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lu3_frz_out", {25'd0, out3}, {25'd0, O_FREEZE});
    edge_step();
    chk("lu3_frz_state", {30'd0, st3}, 32'd2);
    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu3_b2_out", {25'd0, out3}, {25'd0, O_STALL});
    edge_step();
    chk("lu3_b2_state", {30'd0, st3}, 32'd1);
    @(negedge clk);
    chk("lu3_b3_out", {25'd0, out3}, {25'd0, O_STALL});
    edge_step();
    chk("lu3_b3_state", {30'd0, st3}, 32'd0);
    @(negedge clk);
    chk("lu3_done_out", {25'd0, out3}, {25'd0, O_RUN});
    chk("lu3_count", {16'd0, cnt3}, 32'd4);
    edge_step();

    // Branch during a bubble sequence cancels the remaining bubbles.
    hazard_in();
    edge_step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lu3_br_out", {25'd0, out3}, {25'd0, O_BRANCH});
    edge_step();
    chk("lu3_br_state", {30'd0, st3}, 32'd0);
    idle_in();
    @(negedge clk);
    chk("lu3_br_after", {25'd0, out3}, {25'd0, O_RUN});
    edge_step();

    // Reset in the middle of a bubble sequence.
    hazard_in();
    edge_step();
    chk("lu3_rst_pre", {30'd0, st3}, 32'd1);
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    chk("lu3_rst_out", {25'd0, out3}, {25'd0, O_RESET});
    edge_step();
    chk("lu3_rst_state", {30'd0, st3}, 32'd0);
    chk("lu3_rst_count", {16'd0, cnt3}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("lu3_rst_after", {25'd0, out3}, {25'd0, O_RUN});
    edge_step();

    // Saturation of a 4-bit counter.
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) edge_step();
    chk("sat_15", {28'd0, cnts}, 32'd15);
    for (int i = 0; i < 5; i++) edge_step();
    chk("sat_20", {28'd0, cnts}, 32'd15);
    chk("nosat_20", {16'd0, cnt0}, 32'd20);
    idle_in();
    edge_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
